seven_seg_scanner: RTL and testbench

//  Time-multiplexed driver for a 4-digit common-anode 7-segment display.

---
 rtl/sevseg_pkg.sv | 31 +++
 rtl/sevenSegDec.sv | 38 +++
 rtl/seven_seg_scanner.sv | 136 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// ----------------------------------------------------------------------------
// sevseg_pkg
//   Shared constants, types and helpers for the seven-segment scanner.
//   SEG_BLANK : all segments off (active-low)
//   AN_OFF    : all anodes off (active-low)
//   digit_idx_t / seg_t : digit index and segment vector types
//   lead_zero : true when digit k>0 sits inside a run of leading zeros
// ----------------------------------------------------------------------------
package sevseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] digit_idx_t;
   typedef logic [6:0] seg_t;

   // Digit k is a leading zero when it and every digit to its left are 0.
   // Digit 0 is never a leading zero so a value of 0 still shows "0".
   function automatic logic lead_zero(input logic [15:0] v, input digit_idx_t k);
      logic z;
      z = 1'b0;
      case (k)
         2'd1:    z = (v[15:4]  == 12'h000);
         2'd2:    z = (v[15:8]  == 8'h00);
         2'd3:    z = (v[15:12] == 4'h0);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/sevenSegDec.sv
// ----------------------------------------------------------------------------
// sevenSegDec
//   Combinational hex-to-segment decoder, active-low outputs.
//   Ports:
//     nibble : in  4 hex digit 0..F
//     seg    : out 7 segments a..g on seg[0]..seg[6], 0 = segment lit
// ----------------------------------------------------------------------------
module sevenSegDec
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// ----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   A 16-bit value is captured into a shadow register on load and promoted
//   to the displayed (active) register only at a frame boundary, so a frame
//   never mixes old and new digits. One digit is shown per prescaler tick.
//
//   Parameters:
//     TICK_DIV : clk cycles per digit slot (>= 2)
//     CNT_W    : prescaler width, >= clog2(TICK_DIV)
//   Ports:
//     clk    : in  1  system clock, rising edge
//     rst    : in  1  synchronous active-high reset
//     value  : in  16 hex value, nibble k on digit k (digit 0 rightmost)
//     load   : in  1  strobe: capture value and dp_in
//     dp_in  : in  4  decimal point enables per digit, active-high
//     enable : in  1  0 = anodes off, scanning continues
//     an     : out 4  digit anodes, active-low
//     seg    : out 7  segments a..g, active-low
//     dp     : out 1  decimal point, active-low
//
//   Build option: define SEVSEG_LZ_BLANK_EN to blank leading-zero digits
//   (digit 0 always shown, anode still driven, dp unaffected).
//
//   Handshake: load has no ready; every load strobe is accepted. A later
//   load in the same frame overwrites an earlier one.
// ----------------------------------------------------------------------------
module seven_seg_scanner
   import sevseg_pkg::*;
#(
   parameter int TICK_DIV = 100_000,
   parameter int CNT_W    = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   input  logic [3:0]  dp_in,
   input  logic        enable,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             frame_tick;
   digit_idx_t       idx;
   digit_idx_t       next_idx;

   logic [15:0]      shadow;
   logic [3:0]       shadow_dp;
   logic             pending;
   logic [15:0]      active;
   logic [3:0]       active_dp;

   // Active value as it will be after this cycle's edge; the pins for the
   // next slot are computed from this so a promotion shows up immediately.
   logic [15:0]      active_nxt;
   logic [3:0]       active_dp_nxt;

   logic [3:0]       nib;
   seg_t             dec_seg;
   seg_t             seg_nxt;

   assign tick       = (cnt == CNT_W'(TICK_DIV - 1));
   assign next_idx   = idx + 2'd1;
   assign frame_tick = tick && (idx == 2'd3);

   always_comb begin
      active_nxt    = active;
      active_dp_nxt = active_dp;
      if (frame_tick) begin
         // A load landing on the boundary bypasses the shadow register.
         if (load) begin
            active_nxt    = value;
            active_dp_nxt = dp_in;
         end else if (pending) begin
            active_nxt    = shadow;
            active_dp_nxt = shadow_dp;
         end
      end
   end

   assign nib = active_nxt[{next_idx, 2'b00} +: 4];

   sevenSegDec u_dec (
      .nibble (nib),
      .seg    (dec_seg)
   );

`ifdef SEVSEG_LZ_BLANK_EN
   assign seg_nxt = lead_zero(active_nxt, next_idx) ? SEG_BLANK : dec_seg;
`else
   assign seg_nxt = dec_seg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= 2'd0;
         shadow    <= 16'h0000;
         shadow_dp <= 4'h0;
         pending   <= 1'b0;
         active    <= 16'h0000;
         active_dp <= 4'h0;
         an        <= AN_OFF;
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;

         if (load) begin
            shadow    <= value;
            shadow_dp <= dp_in;
            pending   <= 1'b1;
         end

         // Placed after the load branch so a coincident load does not
         // leave pending set for a value that is already active.
         if (frame_tick) begin
            active    <= active_nxt;
            active_dp <= active_dp_nxt;
            pending   <= 1'b0;
         end

         if (tick) begin
            idx <= next_idx;
            an  <= enable ? ~(4'b0001 << next_idx) : AN_OFF;
            seg <= seg_nxt;
            dp  <= ~active_dp_nxt[next_idx];
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Directed, table-driven bench for seven_seg_scanner with TICK_DIV=4.
//   Each table row describes one digit slot (4 clocks ending in a tick):
//   optional load cycle, inputs, and the hand-decoded pin state after the
//   tick. Reset hold and mid-slot reset are hand-written sequences.
//   Segment codes (active-low a..g): 0=40 1=79 2=24 5=12 6=02 7=78 8=00
//   A=08 B=03 C=46 D=21 F=0E, blank=7F.
// ----------------------------------------------------------------------------
`ifdef SEVSEG_LZ_BLANK_EN
`define EXP_LZ(s) 7'h7F
`else
`define EXP_LZ(s) s
`endif

module tb_seven_seg_scanner;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_in;
   logic        enable;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          load_cyc;   // -1 = no load, else cycle 0..3 of the slot
      logic [15:0] value;
      logic [3:0]  dp_in;
      logic        en;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
      logic        exp_dp;
   } vec_t;

   vec_t main_tab[$];
   vec_t post_tab[$];

   seven_seg_scanner #(.TICK_DIV(4), .CNT_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .value  (value),
      .load   (load),
      .dp_in  (dp_in),
      .enable (enable),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int lc, input logic [15:0] v, input logic [3:0] d,
                               input logic e, input logic [3:0] xa, input logic [6:0] xs,
                               input logic xd);
      vec_t r;
      r.load_cyc = lc;
      r.value    = v;
      r.dp_in    = d;
      r.en       = e;
      r.exp_an   = xa;
      r.exp_seg  = xs;
      r.exp_dp   = xd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_pins(input string nm, input logic [3:0] xa, input logic [6:0] xs,
                           input logic xd);
      chk({nm, " an"},  {12'h000, an},  {12'h000, xa});
      chk({nm, " seg"}, {9'h000, seg},  {9'h000, xs});
      chk({nm, " dp"},  {15'h0000, dp}, {15'h0000, xd});
   endtask

   // Driver: one digit slot, starting and ending on a falling edge.
   task automatic run_slot(input string nm, input vec_t v);
      for (int c = 0; c < 4; c++) begin
         value  = v.value;
         dp_in  = v.dp_in;
         enable = v.en;
         load   = (c == v.load_cyc);
         @(posedge clk);
         @(negedge clk);
         load = 1'b0;
      end
      chk_pins(nm, v.exp_an, v.exp_seg, v.exp_dp);
   endtask

   initial begin
      // ticks after reset: 1..24. idx starts at 0, so tick n shows digit n mod 4.
      main_tab.push_back(mk(0,  16'h12AB, 4'b0100, 1'b1, 4'b1011, `EXP_LZ(7'h40), 1'b1)); // t2 load pending
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b0111, `EXP_LZ(7'h40), 1'b1)); // t3
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b1110, 7'h03, 1'b1));          // t4 B
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b1101, 7'h08, 1'b1));          // t5 A
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b1011, 7'h24, 1'b0));          // t6 2 dp
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b0111, 7'h79, 1'b1));          // t7 1
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b1110, 7'h03, 1'b1));          // t8 B
      main_tab.push_back(mk(-1, 16'h12AB, 4'b0100, 1'b1, 4'b1101, 7'h08, 1'b1));          // t9 A
      main_tab.push_back(mk(1,  16'hFFFF, 4'b0001, 1'b1, 4'b1011, 7'h24, 1'b0));          // t10 load mid-frame
      main_tab.push_back(mk(-1, 16'hFFFF, 4'b0001, 1'b1, 4'b0111, 7'h79, 1'b1));          // t11 old value
      main_tab.push_back(mk(-1, 16'hFFFF, 4'b0001, 1'b1, 4'b1110, 7'h0E, 1'b0));          // t12 F dp
      main_tab.push_back(mk(-1, 16'hFFFF, 4'b0001, 1'b1, 4'b1101, 7'h0E, 1'b1));          // t13
      main_tab.push_back(mk(-1, 16'hFFFF, 4'b0001, 1'b1, 4'b1011, 7'h0E, 1'b1));          // t14
      main_tab.push_back(mk(0,  16'h1234, 4'b0000, 1'b1, 4'b0111, 7'h0E, 1'b1));          // t15 load 1234
      main_tab.push_back(mk(3,  16'h0C0D, 4'b1000, 1'b1, 4'b1110, 7'h21, 1'b1));          // t16 load on boundary
      main_tab.push_back(mk(-1, 16'h0C0D, 4'b1000, 1'b1, 4'b1101, 7'h40, 1'b1));          // t17 0
      main_tab.push_back(mk(0,  16'h9999, 4'b0000, 1'b1, 4'b1011, 7'h46, 1'b1));          // t18 C, load 9999
      main_tab.push_back(mk(2,  16'h5678, 4'b0000, 1'b1, 4'b0111, `EXP_LZ(7'h40), 1'b0)); // t19 load 5678
      main_tab.push_back(mk(-1, 16'h5678, 4'b0000, 1'b1, 4'b1110, 7'h00, 1'b1));          // t20 last load wins
      main_tab.push_back(mk(-1, 16'h5678, 4'b0000, 1'b0, 4'b1111, 7'h78, 1'b1));          // t21 dark
      main_tab.push_back(mk(-1, 16'h5678, 4'b0000, 1'b0, 4'b1111, 7'h02, 1'b1));          // t22 dark
      main_tab.push_back(mk(-1, 16'h5678, 4'b0000, 1'b1, 4'b0111, 7'h12, 1'b1));          // t23 resume digit 3
      main_tab.push_back(mk(-1, 16'h5678, 4'b0000, 1'b1, 4'b1110, 7'h00, 1'b1));          // t24

      // after a mid-slot reset: active must be 0 again
      post_tab.push_back(mk(-1, 16'h0000, 4'b0000, 1'b1, 4'b1101, `EXP_LZ(7'h40), 1'b1)); // t1
      post_tab.push_back(mk(0,  16'h0050, 4'b0000, 1'b1, 4'b1011, `EXP_LZ(7'h40), 1'b1)); // t2 load 0050
      post_tab.push_back(mk(-1, 16'h0050, 4'b0000, 1'b1, 4'b0111, `EXP_LZ(7'h40), 1'b1)); // t3
      post_tab.push_back(mk(-1, 16'h0050, 4'b0000, 1'b1, 4'b1110, 7'h40, 1'b1));          // t4 digit0 0
      post_tab.push_back(mk(-1, 16'h0050, 4'b0000, 1'b1, 4'b1101, 7'h12, 1'b1));          // t5 digit1 5
      post_tab.push_back(mk(-1, 16'h0050, 4'b0000, 1'b1, 4'b1011, `EXP_LZ(7'h40), 1'b1)); // t6
      post_tab.push_back(mk(-1, 16'h0050, 4'b0000, 1'b1, 4'b0111, `EXP_LZ(7'h40), 1'b1)); // t7
      post_tab.push_back(mk(3,  16'h0000, 4'b0000, 1'b1, 4'b1110, 7'h40, 1'b1));          // t8 load 0 on boundary
      post_tab.push_back(mk(-1, 16'h0000, 4'b0000, 1'b1, 4'b1101, `EXP_LZ(7'h40), 1'b1)); // t9

      rst    = 1'b1;
      value  = 16'h0000;
      load   = 1'b0;
      dp_in  = 4'h0;
      enable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_pins("reset", 4'b1111, 7'h7F, 1'b1);
      rst = 1'b0;

      // reset values hold until the first tick (4th edge after release)
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk_pins($sformatf("hold%0d", c), 4'b1111, 7'h7F, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      chk_pins("tick1", 4'b1101, `EXP_LZ(7'h40), 1'b1);

      foreach (main_tab[i]) run_slot($sformatf("main t%0d", i + 2), main_tab[i]);

      // reset in the middle of a slot after a load
      load  = 1'b1;
      value = 16'hABCD;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      rst  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_pins("midrst", 4'b1111, 7'h7F, 1'b1);
      rst = 1'b0;

      foreach (post_tab[i]) run_slot($sformatf("post t%0d", i + 1), post_tab[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`undef EXP_LZ
